// File: rtl/axi4_lite_slave_mem_responder_pkg.sv
// Shared AXI4-Lite definitions for the slave memory responder.
//   - brespEnum / rrespEnum : response encodings driven on bresp / rresp
//   - DELAY_WIDTH           : default width of the ready-delay inputs
//   - write/read FSM state enumerations
package axi4_lite_slave_mem_responder_pkg;

  localparam int DELAY_WIDTH = 4;

  typedef enum logic [1:0] {
    WRITE_OKAY   = 2'b00,
    WRITE_EXOKAY = 2'b01,
    WRITE_SLVERR = 2'b10,
    WRITE_DECERR = 2'b11
  } brespEnum;

  typedef enum logic [1:0] {
    READ_OKAY   = 2'b00,
    READ_EXOKAY = 2'b01,
    READ_SLVERR = 2'b10,
    READ_DECERR = 2'b11
  } rrespEnum;

  typedef enum logic [1:0] {
    W_IDLE,
    W_DELAY,
    W_ACCEPT,
    W_RESP
  } axi4LiteSlaveWriteStateEnum;

  typedef enum logic [1:0] {
    R_IDLE,
    R_DELAY,
    R_ACCEPT,
    R_RESP
  } axi4LiteSlaveReadStateEnum;

endpackage

// File: rtl/axi4_lite_slave_mem_responder_if.sv
// AXI4-Lite bus bundle between a master agent and the slave memory responder.
//   write address : awvalid, awready, awaddr, awprot
//   write data    : wvalid, wready, wdata, wstrb
//   write resp    : bvalid, bready, bresp
//   read address  : arvalid, arready, araddr, arprot
//   read data     : rvalid, rready, rdata, rresp
// Modports: slave (responder side), master (agent side).
interface axi4_lite_slave_mem_responder_if #(
  parameter int unsigned ADDRESS_WIDTH = 32,
  parameter int unsigned DATA_WIDTH    = 32
);

  logic                      awvalid;
  logic                      awready;
  logic [ADDRESS_WIDTH-1:0]  awaddr;
  logic [2:0]                awprot;

  logic                      wvalid;
  logic                      wready;
  logic [DATA_WIDTH-1:0]     wdata;
  logic [DATA_WIDTH/8-1:0]   wstrb;

  logic                      bvalid;
  logic                      bready;
  logic [1:0]                bresp;

  logic                      arvalid;
  logic                      arready;
  logic [ADDRESS_WIDTH-1:0]  araddr;
  logic [2:0]                arprot;

  logic                      rvalid;
  logic                      rready;
  logic [DATA_WIDTH-1:0]     rdata;
  logic [1:0]                rresp;

  modport slave (
    input  awvalid, awaddr, awprot,
    input  wvalid, wdata, wstrb,
    input  bready,
    input  arvalid, araddr, arprot,
    input  rready,
    output awready, wready, bvalid, bresp,
    output arready, rvalid, rdata, rresp
  );

  modport master (
    output awvalid, awaddr, awprot,
    output wvalid, wdata, wstrb,
    output bready,
    output arvalid, araddr, arprot,
    output rready,
    input  awready, wready, bvalid, bresp,
    input  arready, rvalid, rdata, rresp
  );

endinterface

// File: rtl/axi4_lite_slave_mem_responder_ready_delay_counter.sv
// Down-counter that times the ready back-pressure of one AXI4-Lite channel.
//   clk, rst  : clock, synchronous active-high reset
//   i_load    : load i_value (takes priority over decrement)
//   i_value   : delay to load
//   i_dec     : decrement by one (saturates at zero)
//   o_done    : count has reached 1, i.e. the last delay cycle
module axi4_lite_ready_delay_counter #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_value,
  input  logic             i_dec,
  output logic             o_done
);

  logic [WIDTH-1:0] r_count;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_value;
    end else if (i_dec && (r_count != '0)) begin
      r_count <= r_count - WIDTH'(1);
    end
  end

  assign o_done = (r_count == WIDTH'(1));

endmodule

// File: rtl/axi4_lite_slave_mem_responder.sv
// AXI4-Lite slave that terminates master traffic into a small word memory.
//   aclk, areset        : clock, synchronous active-high reset
//   bus                 : AXI4-Lite slave modport (all five channels)
//   writeDelayForReady  : extra cycles before awready/wready, latched per transfer
//   readDelayForReady   : extra cycles before arready, latched per transfer
// Write and read paths are independent FSMs; all bus outputs come from
// registers or are decoded from FSM state.
module axi4_lite_slave_mem_responder
  import axi4_lite_slave_mem_responder_pkg::*;
#(
  parameter int unsigned              ADDRESS_WIDTH = 32,
  parameter int unsigned              DATA_WIDTH    = 32,
  parameter int unsigned              DELAY_WIDTH   = axi4_lite_slave_mem_responder_pkg::DELAY_WIDTH,
  parameter int unsigned              MEM_DEPTH     = 16,
  parameter logic [ADDRESS_WIDTH-1:0] BASE_ADDR     = '0
) (
  input  logic                   aclk,
  input  logic                   areset,
  axi4_lite_slave_mem_responder_if.slave bus,
  input  logic [DELAY_WIDTH-1:0] writeDelayForReady,
  input  logic [DELAY_WIDTH-1:0] readDelayForReady
);

  localparam int unsigned              STRB_W      = DATA_WIDTH / 8;
  localparam int unsigned              ADDR_LSB    = $clog2(STRB_W);
  localparam int unsigned              IDX_W       = $clog2(MEM_DEPTH);
  localparam logic [ADDRESS_WIDTH-1:0] DEPTH_WORDS = ADDRESS_WIDTH'(MEM_DEPTH);

  logic [DATA_WIDTH-1:0] r_mem [MEM_DEPTH];

  axi4LiteSlaveWriteStateEnum r_w_state, w_w_next;
  axi4LiteSlaveReadStateEnum  r_r_state, w_r_next;

  brespEnum              r_bresp;
  rrespEnum              r_rresp;
  logic [DATA_WIDTH-1:0] r_rdata;

  // ---------------------------------------------------------------- decode
  // Byte offset bits fall out of the shift, so unaligned addresses hit the
  // containing word. Addresses below BASE_ADDR wrap to a huge word index and
  // are additionally excluded by the explicit >= test.
  logic [ADDRESS_WIDTH-1:0] w_aw_word, w_ar_word;
  logic                     w_aw_in_range, w_ar_in_range;
  logic [IDX_W-1:0]         w_aw_idx, w_ar_idx;

  assign w_aw_word     = (bus.awaddr - BASE_ADDR) >> ADDR_LSB;
  assign w_ar_word     = (bus.araddr - BASE_ADDR) >> ADDR_LSB;
  assign w_aw_in_range = (bus.awaddr >= BASE_ADDR) && (w_aw_word < DEPTH_WORDS);
  assign w_ar_in_range = (bus.araddr >= BASE_ADDR) && (w_ar_word < DEPTH_WORDS);
  assign w_aw_idx      = w_aw_word[IDX_W-1:0];
  assign w_ar_idx      = w_ar_word[IDX_W-1:0];

  // Protection attributes are accepted and deliberately ignored.
  logic w_prot_unused;
  assign w_prot_unused = ^{bus.awprot, bus.arprot};

  // --------------------------------------------------------- write channel
  logic w_wr_start, w_wr_hs, w_wr_cnt_done;

  assign w_wr_start = (r_w_state == W_IDLE) && bus.awvalid && bus.wvalid;
  assign w_wr_hs    = (r_w_state == W_ACCEPT) && bus.awvalid && bus.wvalid;

  axi4_lite_ready_delay_counter #(
    .WIDTH (DELAY_WIDTH)
  ) u_wr_delay (
    .clk     (aclk),
    .rst     (areset),
    .i_load  (w_wr_start),
    .i_value (writeDelayForReady),
    .i_dec   (r_w_state == W_DELAY),
    .o_done  (w_wr_cnt_done)
  );

  always_ff @(posedge aclk) begin
    if (areset) begin
      r_w_state <= W_IDLE;
    end else begin
      r_w_state <= w_w_next;
    end
  end

  always_comb begin
    w_w_next = r_w_state;
    case (r_w_state)
      W_IDLE: begin
        if (w_wr_start) begin
          w_w_next = (writeDelayForReady == '0) ? W_ACCEPT : W_DELAY;
        end
      end
      W_DELAY: begin
        if (w_wr_cnt_done) begin
          w_w_next = W_ACCEPT;
        end
      end
      W_ACCEPT: begin
        if (w_wr_hs) begin
          w_w_next = W_RESP;
        end
      end
      W_RESP: begin
        if (bus.bready) begin
          w_w_next = W_IDLE;
        end
      end
      default: w_w_next = W_IDLE;
    endcase
  end

  assign bus.awready = (r_w_state == W_ACCEPT);
  assign bus.wready  = (r_w_state == W_ACCEPT);
  assign bus.bvalid  = (r_w_state == W_RESP);
  assign bus.bresp   = r_bresp;

  // ---------------------------------------------------------- read channel
  logic w_rd_start, w_rd_hs, w_rd_cnt_done;

  assign w_rd_start = (r_r_state == R_IDLE) && bus.arvalid;
  assign w_rd_hs    = (r_r_state == R_ACCEPT) && bus.arvalid;

  axi4_lite_ready_delay_counter #(
    .WIDTH (DELAY_WIDTH)
  ) u_rd_delay (
    .clk     (aclk),
    .rst     (areset),
    .i_load  (w_rd_start),
    .i_value (readDelayForReady),
    .i_dec   (r_r_state == R_DELAY),
    .o_done  (w_rd_cnt_done)
  );

  always_ff @(posedge aclk) begin
    if (areset) begin
      r_r_state <= R_IDLE;
    end else begin
      r_r_state <= w_r_next;
    end
  end

  always_comb begin
    w_r_next = r_r_state;
    case (r_r_state)
      R_IDLE: begin
        if (w_rd_start) begin
          w_r_next = (readDelayForReady == '0) ? R_ACCEPT : R_DELAY;
        end
      end
      R_DELAY: begin
        if (w_rd_cnt_done) begin
          w_r_next = R_ACCEPT;
        end
      end
      R_ACCEPT: begin
        if (w_rd_hs) begin
          w_r_next = R_RESP;
        end
      end
      R_RESP: begin
        if (bus.rready) begin
          w_r_next = R_IDLE;
        end
      end
      default: w_r_next = R_IDLE;
    endcase
  end

  assign bus.arready = (r_r_state == R_ACCEPT);
  assign bus.rvalid  = (r_r_state == R_RESP);
  assign bus.rdata   = r_rdata;
  assign bus.rresp   = r_rresp;

  // ----------------------------------------------------- memory + responses
  // Read data is sampled from r_mem with the same non-blocking update that
  // commits a write, so a same-edge read of the written word sees old data.
  always_ff @(posedge aclk) begin
    if (areset) begin
      for (int unsigned i = 0; i < MEM_DEPTH; i++) begin
        r_mem[i] <= '0;
      end
      r_bresp <= WRITE_OKAY;
      r_rresp <= READ_OKAY;
      r_rdata <= '0;
    end else begin
      if (w_wr_hs) begin
        if (w_aw_in_range) begin
          for (int unsigned b = 0; b < STRB_W; b++) begin
            if (bus.wstrb[b]) begin
              r_mem[w_aw_idx][b*8 +: 8] <= bus.wdata[b*8 +: 8];
            end
          end
          r_bresp <= WRITE_OKAY;
        end else begin
          r_bresp <= WRITE_SLVERR;
        end
      end
      if (w_rd_hs) begin
        if (w_ar_in_range) begin
          r_rdata <= r_mem[w_ar_idx];
          r_rresp <= READ_OKAY;
        end else begin
          r_rdata <= '0;
          r_rresp <= READ_SLVERR;
        end
      end
    end
  end

endmodule
